axil_line_responder: RTL and testbench

Memory-side responder for the 128-bit line-transfer AXI-Lite-style bus driven by the cache's refill/write-through initiator. It accepts one transaction at a time, either a line read or a strobed line write. It serves each one from an internal line-organised store after a programmable latency and returns read data or a write response over valid/ready handshakes. The block sits at the far end of the system bus and stands in for main memory in simulation and FPGA builds.

---
 rtl/axil_line_responder.sv | 164 ++++++++++++++++
 tb/tb_axil_line_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_line_responder.sv
// Line-organised memory responder for the 128-bit AXI-Lite-style refill bus; one transaction at a time.
// Optional AXIL_RESP_OOR_CHECK_EN: out-of-range writes are dropped with SLVERR and out-of-range reads return zero.
module axil_line_responder #(
   parameter int LINES         = 4096,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  readAddr_addr,
   input  logic         readAddr_valid,
   output logic         readAddr_ready,
   output logic [127:0] readData_data,
   output logic         readData_valid,
   input  logic         readData_ready,
   input  logic [31:0]  writeAddr_addr,
   input  logic         writeAddr_valid,
   output logic         writeAddr_ready,
   input  logic [127:0] writeData_data,
   input  logic [15:0]  writeData_strb,
   input  logic         writeData_valid,
   output logic         writeData_ready,
   output logic [31:0]  writeResp_msg,
   output logic         writeResp_valid,
   input  logic         writeResp_ready,
   output logic [2:0]   dbg_state
);
   localparam int IDX_W   = $clog2(LINES);
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [2:0] {IDLE, R_LAT, R_DATA, W_COLLECT, W_LAT, W_RESP} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] line_idx;
   logic             line_oor;
   logic [127:0]     wdata;
   logic [15:0]      wstrb;
   logic             have_addr, have_data;
   logic [127:0]     mem [LINES];
   logic             ra_hs, wa_hs, wd_hs, lat_done, commit;
   logic             ra_oor, wa_oor;
   logic             unused_addr;

   // A transfer happens on a rising edge where valid and ready are both high; valid/data
   // outputs are held stable until that edge, and ready never depends on the same channel's valid.
   assign ra_hs    = readAddr_valid  && readAddr_ready;
   assign wa_hs    = writeAddr_valid && writeAddr_ready;
   assign wd_hs    = writeData_valid && writeData_ready;
   assign lat_done = (cnt == '0);
   assign commit   = (state == W_LAT) && lat_done && !line_oor;
   assign dbg_state = state;

`ifdef AXIL_RESP_OOR_CHECK_EN
   assign ra_oor      = |readAddr_addr[31:IDX_W+4];
   assign wa_oor      = |writeAddr_addr[31:IDX_W+4];
   assign unused_addr = ^{readAddr_addr[3:0], writeAddr_addr[3:0]};
`else
   assign ra_oor      = 1'b0;
   assign wa_oor      = 1'b0;
   assign unused_addr = ^{readAddr_addr[31:IDX_W+4], readAddr_addr[3:0],
                          writeAddr_addr[31:IDX_W+4], writeAddr_addr[3:0]};
`endif

   always_comb begin
      readAddr_ready  = 1'b0;
      writeAddr_ready = 1'b0;
      writeData_ready = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               readAddr_ready  = 1'b1;
               writeAddr_ready = !readAddr_valid;
               writeData_ready = !readAddr_valid;
            end
            W_COLLECT: begin
               writeAddr_ready = !have_addr;
               writeData_ready = !have_data;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (ra_hs)               state_next = R_LAT;
            else if (wa_hs && wd_hs) state_next = W_LAT;
            else if (wa_hs || wd_hs) state_next = W_COLLECT;
         end
         R_LAT:     if (lat_done) state_next = R_DATA;
         R_DATA:    if (readData_ready) state_next = IDLE;
         W_COLLECT: if (wa_hs || wd_hs) state_next = W_LAT;
         W_LAT:     if (lat_done) state_next = W_RESP;
         W_RESP:    if (writeResp_ready) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         line_idx        <= '0;
         line_oor        <= 1'b0;
         wdata           <= '0;
         wstrb           <= '0;
         have_addr       <= 1'b0;
         have_data       <= 1'b0;
         readData_data   <= '0;
         readData_valid  <= 1'b0;
         writeResp_msg   <= '0;
         writeResp_valid <= 1'b0;
      end else begin
         state <= state_next;
         if (ra_hs) begin
            line_idx <= readAddr_addr[IDX_W+3:4];
            line_oor <= ra_oor;
            cnt      <= CNT_W'(READ_LATENCY - 1);
         end
         if (wa_hs) begin
            line_idx  <= writeAddr_addr[IDX_W+3:4];
            line_oor  <= wa_oor;
            have_addr <= 1'b1;
         end
         if (wd_hs) begin
            wdata     <= writeData_data;
            wstrb     <= writeData_strb;
            have_data <= 1'b1;
         end
         if (state_next == W_LAT && state != W_LAT)
            cnt <= CNT_W'(WRITE_LATENCY - 1);
         if ((state == R_LAT || state == W_LAT) && !lat_done)
            cnt <= cnt - 1'b1;
         if (state == R_LAT && lat_done) begin
            readData_data  <= line_oor ? '0 : mem[line_idx];
            readData_valid <= 1'b1;
         end
         if (state == R_DATA && readData_ready)
            readData_valid <= 1'b0;
         if (state == W_LAT) begin
            have_addr <= 1'b0;
            have_data <= 1'b0;
         end
         if (state == W_LAT && lat_done) begin
            writeResp_msg   <= line_oor ? 32'h2 : 32'h0;
            writeResp_valid <= 1'b1;
         end
         if (state == W_RESP && writeResp_ready)
            writeResp_valid <= 1'b0;
      end
   end

   // Store has no reset; the commit is gated by state, which reset forces to IDLE.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int k = 0; k < 16; k++)
            if (wstrb[k]) mem[line_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
   end
endmodule

// File: tb/tb_axil_line_responder.sv
// Bench for axil_line_responder: directed cases plus randomized reads/writes against an associative-array line model.
// Define AXIL_RESP_OOR_CHECK_EN for both files to check the out-of-range build.
module tb_axil_line_responder;
   localparam int LINES = 4096;
   localparam int RL    = 2;
   localparam int WL    = 2;
   localparam int IDX_W = $clog2(LINES);
`ifdef AXIL_RESP_OOR_CHECK_EN
   localparam bit OOR_EN = 1'b1;
`else
   localparam bit OOR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  readAddr_addr;
   logic         readAddr_valid, readAddr_ready;
   logic [127:0] readData_data;
   logic         readData_valid, readData_ready;
   logic [31:0]  writeAddr_addr;
   logic         writeAddr_valid, writeAddr_ready;
   logic [127:0] writeData_data;
   logic [15:0]  writeData_strb;
   logic         writeData_valid, writeData_ready;
   logic [31:0]  writeResp_msg;
   logic         writeResp_valid, writeResp_ready;
   logic [2:0]   dbg_state;

   int cyc   = 0;
   int n_cmp = 0;
   int n_err = 0;
   logic [127:0] ref_mem [int];
   logic [127:0] exp_q[$];

   axil_line_responder #(.LINES(LINES), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
      .clk(clk), .rst(rst),
      .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
      .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
      .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
      .writeData_data(writeData_data), .writeData_strb(writeData_strb),
      .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
      .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready),
      .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model
   function automatic bit is_oor(input logic [31:0] a);
      return (a >> (IDX_W + 4)) != 32'h0;
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 4) % LINES);
   endfunction

   function automatic logic [127:0] model_read(input logic [31:0] a);
      if (OOR_EN && is_oor(a)) return 128'h0;
      if (ref_mem.exists(line_of(a))) return ref_mem[line_of(a)];
      return 'x;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
      logic [127:0] v;
      if (OOR_EN && is_oor(a)) return;
      v = ref_mem.exists(line_of(a)) ? ref_mem[line_of(a)] : 'x;
      for (int k = 0; k < 16; k++)
         if (s[k]) v[8*k +: 8] = d[8*k +: 8];
      ref_mem[line_of(a)] = v;
   endfunction

   function automatic logic [31:0] model_msg(input logic [31:0] a);
      return (OOR_EN && is_oor(a)) ? 32'h2 : 32'h0;
   endfunction

   // drivers; gap > 0 delays data after address, gap < 0 delays address after data
   task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                           input int gap, input int bp, output int hs_cyc);
      int a_start, d_start, i, n;
      bit a_done, d_done, a_hs, d_hs, stable;
      logic [31:0] m0;
      a_start = (gap < 0) ? -gap : 0;
      d_start = (gap > 0) ? gap : 0;
      writeAddr_addr = a;
      writeData_data = d;
      writeData_strb = s;
      a_done = 0; d_done = 0; i = 0;
      while (!(a_done && d_done) && i < 200) begin
         writeAddr_valid = !a_done && (i >= a_start);
         writeData_valid = !d_done && (i >= d_start);
         @(negedge clk);
         a_hs = writeAddr_valid && writeAddr_ready;
         d_hs = writeData_valid && writeData_ready;
         if (a_done && !d_done) begin
            check_val("collect_wa_ready", writeAddr_ready, 0);
            check_val("collect_wd_ready", writeData_ready, 1);
         end
         if (d_done && !a_done) begin
            check_val("collect_wa_ready", writeAddr_ready, 1);
            check_val("collect_wd_ready", writeData_ready, 0);
         end
         @(posedge clk); #1;
         if (a_hs) a_done = 1;
         if (d_hs) d_done = 1;
         i++;
      end
      hs_cyc = cyc;
      writeAddr_valid = 0;
      writeData_valid = 0;
      model_write(a, d, s);
      n = 0;
      while (!writeResp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("w_latency", n, WL);
      check_val("w_msg", writeResp_msg, model_msg(a));
      m0 = writeResp_msg;
      stable = 1;
      repeat (bp) begin
         @(posedge clk); #1;
         if (!writeResp_valid || writeResp_msg !== m0) stable = 0;
      end
      if (bp > 0) check_val("w_bp_stable", stable, 1);
      writeResp_ready = 1;
      @(posedge clk); #1;
      writeResp_ready = 0;
      check_val("w_resp_cleared", writeResp_valid, 0);
   endtask

   task automatic do_read(input logic [31:0] a, input int bp, output int done_cyc);
      int i, n;
      bit hs, stable;
      logic [127:0] d0, exp;
      exp_q.push_back(model_read(a));
      readAddr_addr  = a;
      readAddr_valid = 1;
      hs = 0; i = 0;
      while (!hs && i < 200) begin
         @(negedge clk);
         hs = readAddr_ready;
         @(posedge clk); #1;
         i++;
      end
      readAddr_valid = 0;
      n = 0;
      while (!readData_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("r_latency", n, RL);
      exp = exp_q.pop_front();
      check_val("r_data", readData_data, exp);
      d0 = readData_data;
      stable = 1;
      repeat (bp) begin
         @(posedge clk); #1;
         if (!readData_valid || readData_data !== d0) stable = 0;
      end
      if (bp > 0) check_val("r_bp_stable", stable, 1);
      readData_ready = 1;
      @(posedge clk); #1;
      readData_ready = 0;
      done_cyc = cyc;
      check_val("r_valid_cleared", readData_valid, 0);
   endtask

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int t, rd_done, wr_hs, g;
      logic [31:0] a;
      logic [127:0] d;
      rst = 1;
      readAddr_addr = '0;  readAddr_valid = 0;  readData_ready = 0;
      writeAddr_addr = '0; writeAddr_valid = 0;
      writeData_data = '0; writeData_strb = '0; writeData_valid = 0;
      writeResp_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ra_ready", readAddr_ready, 0);
      check_val("rst_wa_ready", writeAddr_ready, 0);
      check_val("rst_wd_ready", writeData_ready, 0);
      check_val("rst_r_valid", readData_valid, 0);
      check_val("rst_r_data", readData_data, 0);
      check_val("rst_b_valid", writeResp_valid, 0);
      check_val("rst_b_msg", writeResp_msg, 0);
      rst = 0;
      #1;
      check_val("idle_ra_ready", readAddr_ready, 1);
      @(posedge clk); #1;

      // basic write/read, partial strobe, zero strobe, split channels
      do_write(32'h40, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 0, 0, t);
      do_read(32'h40, 0, t);
      do_write(32'h40, 128'h0, 16'h000F, 0, 0, t);
      check_val("partial_model", model_read(32'h40), 128'h00112233_44556677_8899AABB_00000000);
      do_read(32'h40, 0, t);
      do_write(32'h40, rand_line(), 16'h0000, 0, 0, t);
      do_read(32'h4C, 0, t);
      do_write(32'h40, rand_line(), 16'hFFFF, 3, 0, t);
      do_read(32'h40, 0, t);
      do_write(32'h40, rand_line(), 16'hF0F0, -2, 0, t);
      do_read(32'h40, 0, t);

      // read wins over a simultaneous write; write follows the read-data handshake
      fork
         do_read(32'h40, 0, rd_done);
         do_write(32'h50, rand_line(), 16'hFFFF, 0, 0, wr_hs);
      join
      check_val("prio_w_after_r", wr_hs, rd_done + 1);
      do_read(32'h50, 0, t);

      // backpressure
      do_read(32'h40, 5, t);
      do_write(32'h40, rand_line(), 16'($urandom), 0, 5, t);
      do_read(32'h40, 0, t);

      // out-of-range address
      do_write(32'h0001_0040, rand_line(), 16'hFFFF, 0, 0, t);
      do_read(32'h40, 0, t);
      do_read(32'h0001_0040, 0, t);

      // reset in W_LAT discards the write
      do_write(32'h80, rand_line(), 16'hFFFF, 0, 0, t);
      writeAddr_addr  = 32'h80;
      writeData_data  = ~model_read(32'h80);
      writeData_strb  = 16'hFFFF;
      writeAddr_valid = 1;
      writeData_valid = 1;
      @(posedge clk); #1;
      writeAddr_valid = 0;
      writeData_valid = 0;
      @(posedge clk); #1;
      rst = 1;
      #1;
      check_val("midrst_b_valid", writeResp_valid, 0);
      check_val("midrst_ra_ready", readAddr_ready, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      check_val("postrst_b_valid", writeResp_valid, 0);
      do_read(32'h80, 0, t);

      // randomized traffic over eight lines plus aliases above the store
      for (int k = 0; k < 8; k++) do_write(32'(k) << 4, rand_line(), 16'hFFFF, 0, 0, t);
      for (int k = 0; k < 60; k++) begin
         a = (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) a = a | 32'h0001_0000;
         if ($urandom_range(0, 1) == 1) begin
            g = int'($urandom_range(0, 6)) - 3;
            d = rand_line();
            do_write(a, d, 16'($urandom), g, int'($urandom_range(0, 3)), t);
         end else begin
            do_read(a, int'($urandom_range(0, 3)), t);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
